// File: rtl/sysid_boot_checker.sv
// Avalon-MM read master that fetches the system-ID and timestamp words after
// reset or on request, and reports whether they match the build-time values.
`timescale 1ns/1ps
module sysid_boot_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1561695745,
   parameter int unsigned READ_LATENCY       = 0,
   parameter int unsigned TIMEOUT_CYCLES     = 255,
   parameter bit          AUTO_START         = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        timestamp_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] timestamp_value
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_ID   = 3'd1,
      ST_WAIT_ID = 3'd2,
      ST_RD_TS   = 3'd3,
      ST_WAIT_TS = 3'd4,
      ST_CHECK   = 3'd5,
      ST_DONE    = 3'd6
   } state_t;

   localparam logic [1:0]  LAT_LAST   = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
   localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [1:0]  lat_cnt_q, lat_cnt_d;
   logic        started_q, started_d;
   logic        done_q, done_d;
   logic        id_ok_q, id_ok_d;
   logic        ts_ok_q, ts_ok_d;
   logic        timeout_q, timeout_d;
   logic [31:0] id_value_q, id_value_d;
   logic [31:0] ts_value_q, ts_value_d;

   logic        reading_id;
   logic        capture;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the same pre-edge values regardless of evaluation order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         stall_cnt_q <= '0;
         lat_cnt_q   <= '0;
         started_q   <= 1'b0;
         done_q      <= 1'b0;
         id_ok_q     <= 1'b0;
         ts_ok_q     <= 1'b0;
         timeout_q   <= 1'b0;
         id_value_q  <= '0;
         ts_value_q  <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         lat_cnt_q   <= lat_cnt_d;
         started_q   <= started_d;
         done_q      <= done_d;
         id_ok_q     <= id_ok_d;
         ts_ok_q     <= ts_ok_d;
         timeout_q   <= timeout_d;
         id_value_q  <= id_value_d;
         ts_value_q  <= ts_value_d;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case
      // statement can infer a latch.
      state_d     = state_q;
      stall_cnt_d = '0;
      lat_cnt_d   = '0;
      started_d   = started_q;
      done_d      = done_q;
      id_ok_d     = id_ok_q;
      ts_ok_d     = ts_ok_q;
      timeout_d   = timeout_q;
      id_value_d  = id_value_q;
      ts_value_d  = ts_value_q;
      reading_id  = (state_q == ST_RD_ID) || (state_q == ST_WAIT_ID);
      capture     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start || (AUTO_START && !started_q)) begin
               state_d   = ST_RD_ID;
               started_d = 1'b1;
            end
         end

         ST_RD_ID, ST_RD_TS: begin
            if (avm_waitrequest) begin
               // The stall counter saturates by aborting; it never wraps.
               if (stall_cnt_q == STALL_LAST) begin
                  state_d   = ST_DONE;
                  timeout_d = 1'b1;
                  done_d    = 1'b1;
                  id_ok_d   = 1'b0;
                  ts_ok_d   = 1'b0;
               end else begin
                  stall_cnt_d = stall_cnt_q + 16'd1;
               end
            end else if (READ_LATENCY == 0) begin
               capture = 1'b1;
            end else begin
               state_d = reading_id ? ST_WAIT_ID : ST_WAIT_TS;
            end
         end

         ST_WAIT_ID, ST_WAIT_TS: begin
            if (lat_cnt_q == LAT_LAST) begin
               capture = 1'b1;
            end else begin
               lat_cnt_d = lat_cnt_q + 2'd1;
            end
         end

         ST_CHECK: begin
            id_ok_d = (id_value_q == EXPECTED_ID);
            ts_ok_d = (ts_value_q == EXPECTED_TIMESTAMP);
            done_d  = 1'b1;
            state_d = ST_DONE;
         end

         ST_DONE: begin
            if (start) begin
               done_d    = 1'b0;
               id_ok_d   = 1'b0;
               ts_ok_d   = 1'b0;
               timeout_d = 1'b0;
               state_d   = ST_RD_ID;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      if (capture) begin
         if (reading_id) begin
            id_value_d = avm_readdata;
            state_d    = ST_RD_TS;
         end else begin
            ts_value_d = avm_readdata;
            state_d    = ST_CHECK;
         end
      end
   end

   // Bus strobes are pure state decodes, so they cannot change while stalled.
   assign avm_read        = (state_q == ST_RD_ID) || (state_q == ST_RD_TS);
   assign avm_address     = (state_q == ST_RD_TS);
   assign busy            = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done            = done_q;
   assign id_ok           = id_ok_q;
   assign timestamp_ok    = ts_ok_q;
   assign timeout         = timeout_q;
   assign id_value        = id_value_q;
   assign timestamp_value = ts_value_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench for sysid_boot_checker: a zero-latency instance with default
// parameters and a latency-2 / short-timeout / manual-start instance.
`timescale 1ns/1ps
module tb_sysid_boot_checker;

   localparam logic [31:0] TS_GOOD = 32'd1561695745;
   localparam logic [31:0] B_ID    = 32'h1234_5678;
   localparam logic [31:0] JUNK    = 32'hDEAD_BEEF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: defaults (latency 0, timeout 255, auto start)
   logic        a_rst_n = 1'b0, a_start = 1'b0;
   logic        a_addr, a_read, a_wr, a_busy, a_done, a_iok, a_tok, a_to;
   logic [31:0] a_rdata, a_id, a_ts;
   logic [31:0] a_ts_src = TS_GOOD;
   int          a_stall = 0;
   int          a_scnt  = 0;

   // Instance B: latency 2, timeout 8, manual start
   logic        b_rst_n = 1'b0, b_start = 1'b0, b_stuck = 1'b0;
   logic        b_addr, b_read, b_wr, b_busy, b_done, b_iok, b_tok, b_to;
   logic [31:0] b_rdata, b_id, b_ts;
   logic        b_v1 = 1'b0, b_v2 = 1'b0, b_a1 = 1'b0, b_a2 = 1'b0;

   sysid_boot_checker u_dut_a (
      .clock(clk), .reset_n(a_rst_n), .start(a_start),
      .avm_address(a_addr), .avm_read(a_read), .avm_waitrequest(a_wr),
      .avm_readdata(a_rdata), .busy(a_busy), .done(a_done), .id_ok(a_iok),
      .timestamp_ok(a_tok), .timeout(a_to), .id_value(a_id),
      .timestamp_value(a_ts)
   );

   sysid_boot_checker #(
      .EXPECTED_ID(B_ID), .READ_LATENCY(2), .TIMEOUT_CYCLES(8), .AUTO_START(1'b0)
   ) u_dut_b (
      .clock(clk), .reset_n(b_rst_n), .start(b_start),
      .avm_address(b_addr), .avm_read(b_read), .avm_waitrequest(b_wr),
      .avm_readdata(b_rdata), .busy(b_busy), .done(b_done), .id_ok(b_iok),
      .timestamp_ok(b_tok), .timeout(b_to), .id_value(b_id),
      .timestamp_value(b_ts)
   );

   // Slave A: combinational data, programmable stall count per read
   assign a_wr    = a_read && (a_scnt < a_stall);
   assign a_rdata = a_addr ? a_ts_src : 32'd0;
   always @(posedge clk) begin
      if (a_read && a_wr) a_scnt <= a_scnt + 1;
      else if (a_read)    a_scnt <= 0;
   end

   // Slave B: data valid only two cycles after the accept, junk otherwise
   assign b_wr    = b_stuck;
   assign b_rdata = b_v2 ? (b_a2 ? TS_GOOD : B_ID) : JUNK;
   always @(posedge clk) begin
      b_v1 <= b_read && !b_wr;
      b_a1 <= b_addr;
      b_v2 <= b_v1;
      b_a2 <= b_a1;
   end

   typedef struct {
      logic [31:0] id;
      logic [31:0] ts;
      logic        iok;
      logic        tok;
      logic        to;
      int          edges;
   } exp_t;

   typedef struct packed {
      logic        rd, addr, busy, done, iok, tok, to;
      logic [31:0] id, ts;
   } obs_t;

   exp_t exp_a_q[$];
   exp_t exp_b_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic obs_t get_obs(input bit sel);
      obs_t o;
      if (sel) o = '{b_read, b_addr, b_busy, b_done, b_iok, b_tok, b_to, b_id, b_ts};
      else     o = '{a_read, a_addr, a_busy, a_done, a_iok, a_tok, a_to, a_id, a_ts};
      return o;
   endfunction

   task automatic push(input bit sel, input logic [31:0] id, input logic [31:0] ts,
                       input logic iok, input logic tok, input logic to, input int edges);
      exp_t e;
      e.id = id; e.ts = ts; e.iok = iok; e.tok = tok; e.to = to; e.edges = edges;
      if (sel) exp_b_q.push_back(e);
      else     exp_a_q.push_back(e);
   endtask

   task automatic check_idle(input bit sel, input string tag);
      obs_t o = get_obs(sel);
      check({tag, "/read"}, o.rd, 1'b0);
      check({tag, "/addr"}, o.addr, 1'b0);
      check({tag, "/busy"}, o.busy, 1'b0);
      check({tag, "/done"}, o.done, 1'b0);
      check({tag, "/id_ok"}, o.iok, 1'b0);
      check({tag, "/ts_ok"}, o.tok, 1'b0);
      check({tag, "/timeout"}, o.to, 1'b0);
      check({tag, "/id_value"}, o.id, 32'd0);
      check({tag, "/ts_value"}, o.ts, 32'd0);
   endtask

   task automatic check_results(input bit sel, input string tag);
      exp_t e;
      obs_t o = get_obs(sel);
      if ((sel ? exp_b_q.size() : exp_a_q.size()) == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s: observed empty scoreboard expected an entry", tag);
         return;
      end
      e = sel ? exp_b_q.pop_front() : exp_a_q.pop_front();
      check({tag, "/done"}, o.done, 1'b1);
      check({tag, "/busy"}, o.busy, 1'b0);
      check({tag, "/id_value"}, o.id, e.id);
      check({tag, "/ts_value"}, o.ts, e.ts);
      check({tag, "/id_ok"}, o.iok, e.iok);
      check({tag, "/ts_ok"}, o.tok, e.tok);
      check({tag, "/timeout"}, o.to, e.to);
   endtask

   // Call with start (or reset release) already driven; counts edges to done.
   // poke >= 0 pulses start once while the check is running.
   task automatic wait_done(input bit sel, input string tag, input int poke);
      int n = 0;
      int want;
      if ((sel ? exp_b_q.size() : exp_a_q.size()) == 0) want = -1;
      else want = sel ? exp_b_q[0].edges : exp_a_q[0].edges;
      while (n < 300) begin
         tick();
         n++;
         a_start = 1'b0;
         b_start = 1'b0;
         if (n == poke) begin
            if (sel) b_start = 1'b1;
            else     a_start = 1'b1;
         end
         if (get_obs(sel).done === 1'b1) break;
      end
      a_start = 1'b0;
      b_start = 1'b0;
      check({tag, "/edges_to_done"}, n, want);
      check_results(sel, tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) tick();
      check_idle(1'b0, "reset_a");
      check_idle(1'b1, "reset_b");

      // Auto start on release: address 0 then 1 on consecutive cycles
      a_rst_n = 1'b1;
      b_rst_n = 1'b1;
      push(1'b0, 32'd0, TS_GOOD, 1'b1, 1'b1, 1'b0, 4);
      tick();
      check("auto/rd_id_read", a_read, 1'b1);
      check("auto/rd_id_addr", a_addr, 1'b0);
      check("auto/busy", a_busy, 1'b1);
      tick();
      check("auto/rd_ts_read", a_read, 1'b1);
      check("auto/rd_ts_addr", a_addr, 1'b1);
      tick();
      check("auto/check_read", a_read, 1'b0);
      check("auto/check_done", a_done, 1'b0);
      tick();
      check_results(1'b0, "auto");
      check("no_auto_b/busy", b_busy, 1'b0);
      check("no_auto_b/read", b_read, 1'b0);

      // Timestamp off by one
      a_ts_src = TS_GOOD - 32'd1;
      push(1'b0, 32'd0, TS_GOOD - 32'd1, 1'b1, 1'b0, 1'b0, 4);
      a_start = 1'b1;
      wait_done(1'b0, "ts_mismatch", -1);

      // Five stall cycles per read: strobes stay put
      a_ts_src = TS_GOOD;
      a_stall  = 5;
      push(1'b0, 32'd0, TS_GOOD, 1'b1, 1'b1, 1'b0, 13);
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("stall/id_cyc%0d", i), {a_read, a_addr, a_busy}, 3'b101);
         tick();
      end
      for (int i = 0; i < 6; i++) begin
         check($sformatf("stall/ts_cyc%0d", i), {a_read, a_addr, a_busy}, 3'b111);
         tick();
      end
      check("stall/not_done_yet", a_done, 1'b0);
      tick();
      check_results(1'b0, "stall");
      a_stall = 0;

      // Reset during RD_TS, auto restart afterwards
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      tick();
      check("rst_a/in_rd_ts", a_addr, 1'b1);
      a_rst_n = 1'b0;
      #1;
      check_idle(1'b0, "rst_a");
      tick();
      a_rst_n = 1'b1;
      push(1'b0, 32'd0, TS_GOOD, 1'b1, 1'b1, 1'b0, 4);
      wait_done(1'b0, "rst_a_rerun", -1);

      // Latency 2 instance
      push(1'b1, B_ID, TS_GOOD, 1'b1, 1'b1, 1'b0, 8);
      b_start = 1'b1;
      wait_done(1'b1, "lat2", -1);

      push(1'b1, B_ID, TS_GOOD, 1'b1, 1'b1, 1'b0, 8);
      b_start = 1'b1;
      wait_done(1'b1, "lat2_start_busy", 4);

      // Stuck waitrequest: abort after eight stall cycles
      b_stuck = 1'b1;
      push(1'b1, B_ID, TS_GOOD, 1'b0, 1'b0, 1'b1, 0);
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("tmo/stall_cyc%0d", i), {b_read, b_addr}, 2'b10);
         tick();
      end
      check("tmo/read_dropped", b_read, 1'b0);
      check_results(1'b1, "tmo");

      // Recovery clears timeout
      b_stuck = 1'b0;
      push(1'b1, B_ID, TS_GOOD, 1'b1, 1'b1, 1'b0, 8);
      b_start = 1'b1;
      wait_done(1'b1, "tmo_recover", -1);

      // Reset during RD_TS without auto start: stays idle until start
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      repeat (3) tick();
      check("rst_b/in_rd_ts", {b_read, b_addr}, 2'b11);
      b_rst_n = 1'b0;
      #1;
      check_idle(1'b1, "rst_b");
      tick();
      b_rst_n = 1'b1;
      repeat (6) tick();
      check_idle(1'b1, "rst_b_stays_idle");
      push(1'b1, B_ID, TS_GOOD, 1'b1, 1'b1, 1'b0, 8);
      b_start = 1'b1;
      wait_done(1'b1, "rst_b_restart", -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sysid_boot_checker.md
Name: sysid_boot_checker

Overview:
- Avalon-MM read master that sequences the system-ID slave after reset or on request.
- Reads the ID word (address 0), then the timestamp word (address 1), and compares both against build-time expected values.
- Exposes pass/fail/timeout status and the captured words to the control and status logic, so the rest of the system can hold off until hardware/software consistency is confirmed.

Parameters:
- EXPECTED_ID, 0: value required at slave address 0.
- EXPECTED_TIMESTAMP, 1561695745: value required at slave address 1.
- READ_LATENCY, 0: cycles from accepted read to valid readdata. Legal range 0..3; 0 means readdata is sampled in the accept cycle.
- TIMEOUT_CYCLES, 255: maximum consecutive waitrequest-high cycles per read before abort. Legal range 1..65535.
- AUTO_START, 1: when 1, a check runs automatically after reset deassertion.

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; requests a (re)check.
- avm_address  out  1  slave word address (0=ID, 1=timestamp).
- avm_read  out  1  read strobe.
- avm_waitrequest  in  1  slave stall; tie 0 for zero-wait slaves.
- avm_readdata  in  32  slave read data.
- busy  out  1  check in progress.
- done  out  1  last check finished; results valid.
- id_ok  out  1  captured ID equals EXPECTED_ID.
- timestamp_ok  out  1  captured timestamp equals EXPECTED_TIMESTAMP.
- timeout  out  1  last check aborted on waitrequest timeout.
- id_value  out  32  captured ID word.
- timestamp_value  out  32  captured timestamp word.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset_n` is asynchronous and active-low. While reset is asserted, all outputs, registers and counters are 0 and the state is IDLE.
- States: IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, CHECK, DONE.
- IDLE: leaves to RD_ID on the first edge with start=1. When AUTO_START=1, it also leaves on the first edge after reset_n deasserts, whether or not start is asserted.
- RD_ID: avm_read=1, avm_address=0. avm_read, avm_address and busy are decoded combinationally from the state.
  - Read is accepted on an edge where avm_waitrequest=0.
  - On accept: if READ_LATENCY=0, capture avm_readdata into id_value and go to RD_TS; otherwise go to WAIT_ID.
- WAIT_ID: avm_read=0. A latency counter counts READ_LATENCY cycles. Data is captured on the edge that ends the READ_LATENCY-th cycle after accept, then go to RD_TS.
- RD_TS / WAIT_TS: identical to RD_ID / WAIT_ID, but with avm_address=1 and capture into timestamp_value. Exit goes to CHECK.
- CHECK: register id_ok and timestamp_ok, set done=1, go to DONE.
- DONE: hold all results. On start=1: clear done, id_ok, timestamp_ok and timeout on that edge, then go to RD_ID. id_value and timestamp_value keep their old values until overwritten.
- busy: 1 in every state except IDLE and DONE.
- Latency: with zero wait states, done rises 3+2*READ_LATENCY edges after the edge that leaves IDLE or DONE.
- Timeout:
  - A 16-bit counter increments on each RD_* cycle with waitrequest=1 and clears on accept or state change.
  - When the count reaches TIMEOUT_CYCLES with waitrequest still high: drop avm_read, set timeout=1, done=1, id_ok=0, timestamp_ok=0, and go to DONE. The counter does not wrap.
- start while busy is ignored, with no queuing.
- Comparisons are full 32-bit equality; there are no partial matches.
- Reset mid-operation returns immediately to IDLE with all outputs 0. An in-flight read is abandoned. If AUTO_START=1, the check restarts after reset release.
- avm_address and avm_read are held stable while avm_waitrequest=1.

Test Plan:
- Defaults, waitrequest=0, model returns 0 at addr 0 and 1561695745 at addr 1, release reset -> avm_address 0 then 1 on consecutive cycles; done=1 on the 3rd edge; id_ok=1, timestamp_ok=1, timeout=0, timestamp_value=1561695745.
- Model returns 1561695744 at addr 1 -> done=1, id_ok=1, timestamp_ok=0, timestamp_value=1561695744.
- waitrequest held high 5 cycles on each read -> address and read stable throughout; done on the 13th edge; both ok flags 1, timeout=0.
- TIMEOUT_CYCLES=8, waitrequest stuck high -> avm_read drops after 8 stall cycles; timeout=1, done=1, id_ok=0, timestamp_ok=0, busy=0.
- READ_LATENCY=2, readdata valid only 2 cycles after accept -> correct capture; done on the 7th edge. Pulsing start in DONE clears done for one check and repeats the sequence; pulsing start while busy has no effect.
- Assert reset_n low during RD_TS -> all outputs 0 asynchronously; after release with AUTO_START=1, a full sequence reruns; with AUTO_START=0, the block stays IDLE until start.
